// File: rtl/uart_debug_pkg.sv
// rtl/uart_debug_pkg.sv - shared constants, state types and character helpers for the hex word UART
//
// Purpose: definitions shared by hex_word_uart_tx and uart_tx_byte.
//   CHAR_CR / CHAR_LF   line terminator bytes
//   N_LINE_CHARS        characters per printed line (8 hex digits + CR + LF)
//   nibble_to_ascii()   4-bit value -> uppercase ASCII hex digit
//   line_char()         character at a given index of the line printed for a word
//   line_state_t        word/line level FSM states
//   byte_state_t        byte framing FSM states
package uart_debug_pkg;

  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_LF      = 8'h0A;
  localparam int         N_LINE_CHARS = 10;

  typedef enum logic {
    LINE_IDLE,
    LINE_SEND
  } line_state_t;

  typedef enum logic [1:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_STOP
  } byte_state_t;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' ('A' - 10 = 0x37).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

  // Index 0 is the most significant nibble; bit offset is 4*(7-idx),
  // which for a 3-bit index is simply the inverted index shifted by two.
  function automatic logic [7:0] line_char(input logic [31:0] w, input logic [3:0] idx);
    if (idx < 4'd8) begin
      return nibble_to_ascii(w[{~idx[2:0], 2'b00} +: 4]);
    end
    if (idx == 4'd8) begin
      return CHAR_CR;
    end
    return CHAR_LF;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with zero-gap back-to-back handoff
//
// Purpose: frames one byte as start(0), data[0..7] LSB first, stop(1), each bit
// held for DIV clock cycles.
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset (tx forced high)
//   byte_valid  a byte is offered
//   byte_ready  byte can be taken: in IDLE, or in the last cycle of the stop bit
//   byte_data   byte to send, captured on valid & ready
//   tx          serial output, registered, idles high
module uart_tx_byte
  import uart_debug_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] byte_data,
  output logic       tx
);

  localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  byte_state_t      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_done;

  assign bit_done = (baud_cnt == CNT_LAST);

  // Ready in the final stop cycle lets the next start bit begin on the very
  // edge the stop bit ends, so consecutive bytes have no idle gap.
  assign byte_ready = (state == BYTE_IDLE) || ((state == BYTE_STOP) && bit_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BYTE_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      if (state != BYTE_IDLE) begin
        baud_cnt <= bit_done ? '0 : baud_cnt + CNT_ONE;
      end

      case (state)
        BYTE_IDLE: begin
          baud_cnt <= '0;
          if (byte_valid) begin
            shift <= byte_data;
            tx    <= 1'b0;
            state <= BYTE_START;
          end
        end

        BYTE_START: begin
          if (bit_done) begin
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= '0;
            state   <= BYTE_DATA;
          end
        end

        BYTE_DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= BYTE_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        BYTE_STOP: begin
          if (bit_done) begin
            bit_idx <= '0;
            if (byte_valid) begin
              shift <= byte_data;
              tx    <= 1'b0;
              state <= BYTE_START;
            end else begin
              state <= BYTE_IDLE;
            end
          end
        end

        default: begin
          state <= BYTE_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/hex_word_uart_tx.sv
// rtl/hex_word_uart_tx.sv - prints 32-bit words as "XXXXXXXX\r\n" lines on a UART TX pin
//
// Purpose: accepts a word on a valid/ready handshake and sends its eight
// uppercase hex digits (MS nibble first) followed by CR LF, 8N1 framing,
// DIV = CLK_FREQUENCY / BAUD_RATE cycles per bit, 100*DIV cycles per line.
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset; abandons any line in progress
//   word_valid  a word is offered
//   word_ready  a word can be accepted this cycle
//   word        value to print, captured on word_valid & word_ready
//   uart_tx     serial line, registered, idles high
//   busy        a line is in progress (~word_ready)
module hex_word_uart_tx
  import uart_debug_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word,
  output logic        uart_tx,
  output logic        busy
);

  localparam int         DIV          = CLK_FREQUENCY / BAUD_RATE;
  localparam logic [3:0] LINE_END_IDX = 4'(N_LINE_CHARS);

  line_state_t line_state;
  logic [31:0] word_reg;
  logic [3:0]  char_idx;   // next character to hand to the serializer
  logic        all_handed;
  logic        word_fire;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;

  assign all_handed = (line_state == LINE_SEND) && (char_idx == LINE_END_IDX);

  // The final cycle of the LF stop bit already counts as idle: a word offered
  // there starts its first start bit on the edge the stop bit ends.
  assign word_ready = (line_state == LINE_IDLE) || (all_handed && byte_ready);
  assign busy       = ~word_ready;
  assign word_fire  = word_valid & word_ready;

  // The first digit comes straight from the input word so its start bit is
  // launched on the accept edge itself.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = line_char(word_reg, char_idx);
    if (word_fire) begin
      byte_valid = 1'b1;
      byte_data  = nibble_to_ascii(word[31:28]);
    end else if ((line_state == LINE_SEND) && (char_idx < LINE_END_IDX)) begin
      byte_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_state <= LINE_IDLE;
      word_reg   <= '0;
      char_idx   <= '0;
    end else if (word_fire) begin
      word_reg   <= word;
      char_idx   <= 4'd1;
      line_state <= LINE_SEND;
    end else if ((line_state == LINE_SEND) && byte_ready) begin
      if (char_idx == LINE_END_IDX) begin
        line_state <= LINE_IDLE;
        char_idx   <= '0;
      end else begin
        char_idx <= char_idx + 4'd1;
      end
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_data (byte_data),
    .tx        (uart_tx)
  );

endmodule

// File: tb/tb_hex_word_uart_tx.sv
// tb/tb_hex_word_uart_tx.sv - self-checking bench for hex_word_uart_tx
module tb_hex_word_uart_tx;

  localparam int DIV_A = 8;
  localparam int DIV_B = 434;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wv_a, wr_a, tx_a, busy_a;
  logic [31:0] w_a;
  logic        wv_b, wr_b, tx_b, busy_b;
  logic [31:0] w_b;

  int    tests = 0;
  int    fails = 0;
  string hx = "0123456789ABCDEF";

  typedef struct {
    logic [31:0] word;
    string       text;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  hex_word_uart_tx #(.CLK_FREQUENCY(8), .BAUD_RATE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .word_valid(wv_a), .word_ready(wr_a),
    .word(w_a), .uart_tx(tx_a), .busy(busy_a)
  );

  hex_word_uart_tx dut_b (
    .clk(clk), .reset_n(reset_n), .word_valid(wv_b), .word_ready(wr_b),
    .word(w_b), .uart_tx(tx_b), .busy(busy_b)
  );

  task automatic check(input bit ok, input string name, input string detail);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic get_tx(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel != 0) ? wr_b : wr_a;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] w);
    if (sel != 0) begin
      wv_b = v;
      w_b  = w;
    end else begin
      wv_a = v;
      w_a  = w;
    end
  endtask

  // Reference model: the line is 10 characters, each 10 bits (0, data LSB first, 1).
  function automatic logic [7:0] char_of(input logic [31:0] w, input int c);
    int nib;
    if (c < 8) begin
      nib = int'((w >> (28 - 4 * c)) & 32'hF);
      return hx[nib];
    end
    return (c == 8) ? 8'h0D : 8'h0A;
  endfunction

  function automatic logic line_bit(input logic [31:0] w, input int b);
    int          n;
    logic [7:0]  ch;
    n = b % 10;
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    ch = char_of(w, b / 10);
    return ch[n - 1];
  endfunction

  function automatic string model_text(input logic [31:0] w);
    string s;
    s = "";
    for (int c = 0; c < 8; c++) s = $sformatf("%s%c", s, char_of(w, c));
    return s;
  endfunction

  task automatic check_idle(input int n, input string name);
    int err;
    err = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_a !== 1'b1 || wr_a !== 1'b1 || busy_a !== 1'b0) err++;
      if (tx_b !== 1'b1 || wr_b !== 1'b1 || busy_b !== 1'b0) err++;
      tick();
    end
    check(err == 0, name, $sformatf("got %0d non-idle samples, required 0", err));
  endtask

  // Offer a word and return at the first sample after the accept edge.
  task automatic start_word(input int sel, input logic [31:0] w);
    int n;
    n = 0;
    drive(sel, 1'b1, w);
    while (get_ready(sel) !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(n < 2000, "accept", $sformatf("got no word_ready in %0d cycles, required accept", n));
    tick();
  endtask

  // Called at the first sample after the accept edge. Checks every cycle of
  // the line against the model, word_ready/busy timing, and the decoded text.
  task automatic check_line(input int sel, input logic [31:0] w, input string exp,
                            input bit noise, input logic nv, input logic [31:0] nw,
                            output logic [31:0] last_w);
    int         d, total, wave_err, rdy_err, b, c;
    logic       txv;
    logic [7:0] ch;
    logic [15:0] tail;
    string      got;
    d        = (sel != 0) ? DIV_B : DIV_A;
    total    = 100 * d;
    wave_err = 0;
    rdy_err  = 0;
    got      = "";
    tail     = '0;
    ch       = '0;
    last_w   = nw;
    for (int t = 0; t < total; t++) begin
      txv = get_tx(sel);
      if (txv !== line_bit(w, t / d)) wave_err++;
      if (t < total - 1) begin
        if (get_ready(sel) !== 1'b0 || get_busy(sel) !== 1'b1) rdy_err++;
      end else begin
        if (get_ready(sel) !== 1'b1 || get_busy(sel) !== 1'b0) rdy_err++;
      end
      if (t % d == d / 2) begin
        b = (t / d) % 10;
        c = t / (10 * d);
        if (b >= 1 && b <= 8) ch[b - 1] = txv;
        if (b == 8) begin
          if (c < 8) got = $sformatf("%s%c", got, ch);
          else       tail = {tail[7:0], ch};
        end
      end
      if (noise) begin
        last_w = $urandom;
        drive(sel, 1'b1, last_w);
      end else if (t == 0) begin
        drive(sel, 1'b0, w);
      end else if (t == total - 1) begin
        drive(sel, nv, nw);
      end
      tick();
    end
    check(wave_err == 0, $sformatf("wave_%h", w),
          $sformatf("got %0d tx cycles off the model waveform, required 0", wave_err));
    check(rdy_err == 0, $sformatf("ready_%h", w),
          $sformatf("got %0d bad word_ready/busy samples, required 0", rdy_err));
    check(got == exp && tail == 16'h0D0A, $sformatf("text_%h", w),
          $sformatf("got %s+%h, required %s+0d0a", got, tail, exp));
  endtask

  initial begin
    logic [31:0] lw, w;
    int          gap;

    vecs[0] = '{32'h0123ABCD, "0123ABCD"};
    vecs[1] = '{32'h0000000A, "0000000A"};
    vecs[2] = '{32'h9F6E5D4C, "9F6E5D4C"};
    vecs[3] = '{32'h7B3C1A85, "7B3C1A85"};

    reset_n = 1'b0;
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    repeat (3) tick();
    check_idle(3, "reset_state");
    reset_n = 1'b1;
    check_idle(1000, "idle_1000");

    // Table vectors, one line each with idle after.
    for (int i = 0; i < 4; i++) begin
      start_word(0, vecs[i].word);
      check_line(0, vecs[i].word, vecs[i].text, 1'b0, 1'b0, 32'h0, lw);
    end

    // Inputs churn while busy; the word present on the next accept edge wins.
    start_word(0, 32'hDEADBEEF);
    check_line(0, 32'hDEADBEEF, "DEADBEEF", 1'b1, 1'b0, 32'h0, lw);
    check_line(0, lw, model_text(lw), 1'b0, 1'b0, 32'h0, w);

    // Back-to-back with word_valid held: no gap between lines.
    start_word(0, 32'hFFFFFFFF);
    check_line(0, 32'hFFFFFFFF, "FFFFFFFF", 1'b0, 1'b1, 32'h00000000, lw);
    check_line(0, 32'h00000000, "00000000", 1'b0, 1'b0, 32'h0, lw);

    // Random words with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      w   = $urandom;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      start_word(0, w);
      check_line(0, w, model_text(w), 1'b0, 1'b0, 32'h0, lw);
    end

    // Reset during data bit 3 of char 2 (bit slot 24 of the line).
    w = 32'h12345678;
    start_word(0, w);
    drive(0, 1'b0, 32'h0);
    repeat (24 * DIV_A + 4) tick();
    check(tx_a === line_bit(w, 24), "pre_reset_tx",
          $sformatf("got %b, required %b", tx_a, line_bit(w, 24)));
    #2;
    reset_n = 1'b0;
    #1;
    check(tx_a === 1'b1 && wr_a === 1'b1 && busy_a === 1'b0, "async_reset",
          $sformatf("got tx=%b ready=%b busy=%b, required 1 1 0", tx_a, wr_a, busy_a));
    repeat (3) tick();
    reset_n = 1'b1;
    check_idle(50, "post_reset_idle");
    start_word(0, 32'h0000000A);
    check_line(0, 32'h0000000A, "0000000A", 1'b0, 1'b0, 32'h0, lw);

    // Default divider: 434 cycles per bit, 43400 per line.
    start_word(1, 32'hC0FFEE42);
    check_line(1, 32'hC0FFEE42, "C0FFEE42", 1'b0, 1'b0, 32'h0, lw);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
